// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage integer ALU with iterative unsigned multiply/divide.
// Single-cycle ops return one cycle after accept. MUL/MULHU/DIVU/REMU iterate
// one bit per cycle. All results and flags are registered and held until the
// consumer takes them.
module alu_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_v,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_XOR   = 4'h4;
   localparam logic [3:0] OP_SLT   = 4'h5;
   localparam logic [3:0] OP_SLL   = 4'h6;
   localparam logic [3:0] OP_SRL   = 4'h7;
   localparam logic [3:0] OP_SRA   = 4'h8;
   localparam logic [3:0] OP_SLTU  = 4'h9;
   localparam logic [3:0] OP_MUL   = 4'hA;
   localparam logic [3:0] OP_MULHU = 4'hB;
   localparam logic [3:0] OP_DIVU  = 4'hC;
   localparam logic [3:0] OP_REMU  = 4'hD;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   typedef struct packed {
      logic v;
      logic c;
      logic z;
      logic n;
   } flags_t;

   state_e             state_q, state_d;
   // acc holds {hi, lo} of the product, or {remainder, quotient/dividend}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // opnd holds the multiplicand (a) or the divisor (b)
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   // selects the upper half of acc as the answer (MULHU, REMU)
   logic               hi_q, hi_d;
   logic [WIDTH-1:0]   res_q, res_d;
   flags_t             flg_q, flg_d;

   logic [SHW-1:0]     shamt;
   logic               is_sub;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_v, alu_c;
   logic               is_mul, is_div;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] iter_acc;
   logic [WIDTH-1:0]   iter_res;

   assign shamt  = b[SHW-1:0];
   assign is_mul = (op == OP_MUL) || (op == OP_MULHU);
   assign is_div = (op == OP_DIVU) || (op == OP_REMU);

   // Shared adder for ADD/SUB; SUB is a + ~b + 1 so carry out means no borrow
   always_comb begin
      is_sub  = (op == OP_SUB);
      b_eff   = is_sub ? ~b : b;
      add_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
   end

   // Single-cycle datapath, also covers divide-by-zero (only used when b == 0)
   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      alu_c   = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            alu_res = add_sum[WIDTH-1:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = ~(a[WIDTH-1] ^ b_eff[WIDTH-1]) & (a[WIDTH-1] ^ add_sum[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_DIVU: alu_res = '1;
         OP_REMU: alu_res = a;
         default: alu_res = '0;
      endcase
   end

   // One iteration step for shift-add multiply and restoring divide
   always_comb begin
      // multiply: add multiplicand into the high half when the low bit is set, then shift right
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      // divide: shift next dividend bit into the remainder, subtract if it fits
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = ~div_diff[WIDTH];
      div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
      iter_acc  = (state_q == S_MUL) ? mul_next : div_next;
      iter_res  = hi_q ? iter_acc[2*WIDTH-1:WIDTH] : iter_acc[WIDTH-1:0];
   end

   // Next-state and datapath register updates
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      res_d   = res_q;
      flg_d   = flg_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               hi_d  = (op == OP_MULHU) || (op == OP_REMU);
               cnt_d = '0;
               if (is_mul) begin
                  state_d = S_MUL;
                  acc_d   = {{WIDTH{1'b0}}, b};
                  opnd_d  = a;
               end else if (is_div && (b != '0)) begin
                  state_d = S_DIV;
                  acc_d   = {{WIDTH{1'b0}}, a};
                  opnd_d  = b;
               end else begin
                  state_d = S_DONE;
                  res_d   = alu_res;
                  flg_d   = '{v: alu_v, c: alu_c, z: (alu_res == '0), n: alu_res[WIDTH-1]};
               end
            end
         end
         S_MUL, S_DIV: begin
            acc_d = iter_acc;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               res_d   = iter_res;
               flg_d   = '{v: 1'b0, c: 1'b0, z: (iter_res == '0), n: iter_res[WIDTH-1]};
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         hi_q    <= 1'b0;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = res_q;
   assign flag_v    = flg_q.v;
   assign flag_c    = flg_q.c;
   assign flag_z    = flg_q.z;
   assign flag_n    = flg_q.n;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: a 32-bit and an 8-bit instance, a behavioural model,
// a per-cycle compare process, literal directed cases and a random stream.
module tb_alu_mdu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  op_i;
   logic [31:0] a_i, b_i;
   logic [1:0]  in_valid;
   logic [1:0]  out_ready;
   logic [1:0]  rnd_or;

   logic        ir0, ov0, v0, c0, z0, n0;
   logic [31:0] r0;
   logic        ir1, ov1, v1, c1, z1, n1;
   logic [7:0]  r1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir0), .op(op_i),
      .a(a_i), .b(b_i), .out_valid(ov0), .out_ready(out_ready[0]), .result(r0),
      .flag_v(v0), .flag_c(c0), .flag_z(z0), .flag_n(n0));

   alu_mdu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1), .op(op_i),
      .a(a_i[7:0]), .b(b_i[7:0]), .out_valid(ov1), .out_ready(out_ready[1]), .result(r1),
      .flag_v(v1), .flag_c(c1), .flag_z(z1), .flag_n(n1));

   function automatic logic get_ir(int d);
      return (d == 0) ? ir0 : ir1;
   endfunction
   function automatic logic get_ov(int d);
      return (d == 0) ? ov0 : ov1;
   endfunction
   function automatic logic [31:0] get_res(int d);
      return (d == 0) ? r0 : {24'h0, r1};
   endfunction
   function automatic logic [3:0] get_flg(int d);
      return (d == 0) ? {v0, c0, z0, n0} : {v1, c1, z1, n1};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;   // {v, c, z, n}
      int          lat;
   } exp_t;

   function automatic longint sx(longint unsigned x, int w);
      if (((x >> (w - 1)) & 1) != 0) return longint'(x) - (longint'(1) <<< w);
      return longint'(x);
   endfunction

   function automatic exp_t model(int w, logic [3:0] op, logic [31:0] ai, logic [31:0] bi);
      exp_t e;
      longint unsigned m, ua, ub, r, p;
      longint sa, sb, s, hi, lo;
      int sh;
      logic v, c;
      m  = (64'd1 << w) - 1;
      ua = ai & m;
      ub = bi & m;
      sa = sx(ua, w);
      sb = sx(ub, w);
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      sh = int'(ub % longint'(w));
      p  = ua * ub;
      r  = 0;
      v  = 1'b0;
      c  = 1'b0;
      e.lat = 1;
      case (op)
         4'd0: begin r = (ua + ub) & m; c = (ua + ub) > m; s = sa + sb; v = (s > hi) || (s < lo); end
         4'd1: begin r = (ua - ub) & m; c = ua >= ub;      s = sa - sb; v = (s > hi) || (s < lo); end
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd5: r = (sa < sb) ? 1 : 0;
         4'd6: r = (ua << sh) & m;
         4'd7: r = ua >> sh;
         4'd8: r = $unsigned(sa >>> sh) & m;
         4'd9: r = (ua < ub) ? 1 : 0;
         4'd10: begin r = p & m;        e.lat = w + 1; end
         4'd11: begin r = (p >> w) & m; e.lat = w + 1; end
         4'd12: begin if (ub == 0) r = m;  else begin r = ua / ub; e.lat = w + 1; end end
         4'd13: begin if (ub == 0) r = ua; else begin r = ua % ub; e.lat = w + 1; end end
         default: r = 0;
      endcase
      e.res = r[31:0];
      e.flg = {v, c, (r == 0), (((r >> (w - 1)) & 1) != 0)};
      return e;
   endfunction

   // ---------------- per-cycle compare process ----------------
   int   cyc = 0;
   bit   armed = 0;
   bit   busy [2];
   int   acc_cyc [2];
   exp_t ex [2];
   int   wd [2] = '{32, 8};
   bit   ovx;

   // Every cycle: handshake outputs match the model's view of occupancy, and
   // while a result is due it must match the model.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         armed   = 1;
         busy[0] = 0;
         busy[1] = 0;
      end else if (armed) begin
         for (int d = 0; d < 2; d++) begin
            ovx = busy[d] && ((cyc - acc_cyc[d]) >= ex[d].lat);
            chk($sformatf("d%0d in_ready cyc%0d", d, cyc), get_ir(d), !busy[d]);
            chk($sformatf("d%0d out_valid cyc%0d", d, cyc), get_ov(d), ovx);
            if (ovx) begin
               chk($sformatf("d%0d result cyc%0d", d, cyc), get_res(d), ex[d].res);
               chk($sformatf("d%0d flags cyc%0d", d, cyc), get_flg(d), ex[d].flg);
               if (out_ready[d]) busy[d] = 0;
            end
            if (in_valid[d] && get_ir(d)) begin
               busy[d]    = 1;
               acc_cyc[d] = cyc;
               ex[d]      = model(wd[d], op_i, a_i, b_i);
            end
         end
      end
   end

   // Random consumer backpressure when enabled
   initial begin
      rnd_or = 2'b00;
      forever begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++)
            if (rnd_or[d]) out_ready[d] = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic scramble();
      op_i = 4'($urandom_range(0, 15));
      a_i  = $urandom;
      b_i  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
   endtask

   task automatic issue(int d, logic [3:0] o, logic [31:0] x, logic [31:0] y);
      bit ok;
      @(posedge clk); #1;
      op_i = o; a_i = x; b_i = y; in_valid[d] = 1'b1;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (get_ir(d)) begin ok = 1; break; end
      end
      chk($sformatf("d%0d accept within bound", d), ok, 1);
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      scramble();
   endtask

   task automatic wait_out(int d, output int lat);
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (get_ov(d)) begin lat = k; break; end
      end
   endtask

   task automatic lit(string name, int d, logic [3:0] o, logic [31:0] x, logic [31:0] y,
                      logic [31:0] er, logic [3:0] ef, int el);
      int lat;
      issue(d, o, x, y);
      wait_out(d, lat);
      chk({name, " latency"}, lat, el);
      chk({name, " result"}, get_res(d), er);
      chk({name, " flags"}, get_flg(d), ef);
   endtask

   task automatic stream(int d, int n);
      bit ok;
      @(posedge clk); #1;
      rnd_or[d]   = 1'b1;
      scramble();
      in_valid[d] = 1'b1;
      for (int i = 0; i < n; i++) begin
         ok = 0;
         for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (get_ir(d)) begin ok = 1; break; end
         end
         chk($sformatf("d%0d stream accept %0d", d, i), ok, 1);
         @(posedge clk); #1;
         scramble();
      end
      in_valid[d]  = 1'b0;
      rnd_or[d]    = 1'b0;
      @(posedge clk); #1;
      out_ready[d] = 1'b1;
      repeat (2 * wd[d] + 10) @(posedge clk);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      exp_t e;
      int   lat, seen;
      logic [31:0] hr;
      logic [3:0]  hf;
      in_valid  = 2'b00;
      out_ready = 2'b11;
      op_i = 4'h0; a_i = 32'h0; b_i = 32'h0;

      // pin the model with hand-computed values
      e = model(32, 4'd0, 32'h7FFFFFFF, 32'h1);
      chk("model add ovf", {e.res, e.flg}, {32'h80000000, 4'b1001});
      e = model(32, 4'd1, 32'h3, 32'h5);
      chk("model sub borrow", {e.res, e.flg}, {32'hFFFFFFFE, 4'b0001});
      e = model(32, 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("model mulhu", {e.res, 4'(e.lat)}, {32'hFFFFFFFE, 4'd1});
      e = model(8, 4'd8, 32'h80, 32'h24);
      chk("model sra8", e.res, 32'hF8);
      e = model(8, 4'd12, 32'd100, 32'd7);
      chk("model divu8", {e.res, 8'(e.lat)}, {32'd14, 8'd9});

      // reset
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset in_ready", ir0, 1);
      chk("reset out_valid", ov0, 0);
      chk("reset result", r0, 0);
      chk("reset flags", {v0, c0, z0, n0}, 0);

      // 32-bit directed cases
      lit("add ovf",   0, 4'h0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1001, 1);
      lit("sub zero",  0, 4'h1, 32'd5,        32'd5,        32'h0,        4'b0110, 1);
      lit("sra",       0, 4'h8, 32'h80000000, 32'h24,       32'hF8000000, 4'b0001, 1);
      lit("slt",       0, 4'h5, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000, 1);
      lit("sltu",      0, 4'h9, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0010, 1);
      lit("mul",       0, 4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        4'b0000, 33);
      lit("mulhu",     0, 4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0001, 33);
      lit("divu",      0, 4'hC, 32'd100,      32'd7,        32'd14,       4'b0000, 33);
      lit("remu",      0, 4'hD, 32'd100,      32'd7,        32'd2,        4'b0000, 33);
      lit("divu by 0", 0, 4'hC, 32'd9,        32'd0,        32'hFFFFFFFF, 4'b0001, 1);
      lit("remu by 0", 0, 4'hD, 32'd9,        32'd0,        32'd9,        4'b0000, 1);
      lit("op 1110",   0, 4'hE, 32'h1234,     32'h5678,     32'h0,        4'b0010, 1);

      // reset in the middle of a multiply
      issue(0, 4'hA, 32'h1234567, 32'h89ABCDE);
      repeat (9) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid-mul reset in_ready", ir0, 1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (ov0) seen++;
      end
      chk("mid-mul reset no out_valid", seen, 0);

      // backpressure on a finished multiply
      out_ready[0] = 1'b0;
      issue(0, 4'hA, 32'd1000, 32'd3000);
      wait_out(0, lat);
      chk("bp latency", lat, 33);
      hr = r0;
      hf = {v0, c0, z0, n0};
      chk("bp result", hr, 32'd3000000);
      repeat (5) begin
         @(negedge clk);
         chk("bp hold result", r0, hr);
         chk("bp hold flags", {v0, c0, z0, n0}, hf);
         chk("bp hold in_ready", ir0, 0);
         chk("bp hold out_valid", ov0, 1);
      end
      @(posedge clk); #1;
      out_ready[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp release in_ready", ir0, 1);

      // 8-bit directed cases
      lit("w8 add ovf",   1, 4'h0, 32'h7F, 32'h01, 32'h80, 4'b1001, 1);
      lit("w8 sub zero",  1, 4'h1, 32'd5,  32'd5,  32'h00, 4'b0110, 1);
      lit("w8 sra",       1, 4'h8, 32'h80, 32'h24, 32'hF8, 4'b0001, 1);
      lit("w8 mul",       1, 4'hA, 32'hFF, 32'hFF, 32'h01, 4'b0000, 9);
      lit("w8 mulhu",     1, 4'hB, 32'hFF, 32'hFF, 32'hFE, 4'b0001, 9);
      lit("w8 divu",      1, 4'hC, 32'd100, 32'd7, 32'd14, 4'b0000, 9);
      lit("w8 remu",      1, 4'hD, 32'd100, 32'd7, 32'd2,  4'b0000, 9);
      lit("w8 divu by 0", 1, 4'hC, 32'd9,   32'd0, 32'hFF, 4'b0001, 1);

      // random back-to-back streams with in_valid held high
      stream(0, 40);
      stream(1, 60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, multi-cycle successor to the core single-cycle integer ALU.
- Adds XOR, shifts, unsigned SLT, iterative unsigned multiply and divide, registered results/flags, and valid/ready handshakes on both sides.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid while multiply/divide iterate.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request
- op  in  4  operation select (encoding below)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- flag_v  out  1  signed overflow (ADD/SUB only, else 0)
- flag_c  out  1  carry out; for SUB 1 = no borrow (ADD/SUB only, else 0)
- flag_z  out  1  result == 0
- flag_n  out  1  result[WIDTH-1]

Behaviour:
- **Reset:** state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0. rst overrides everything, including mid-multiply/divide; any in-flight op is discarded without output.
- **op encoding:**
  - 0000 ADD, 0001 SUB (a+~b+1), 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed, zero-extended 1-bit).
  - 0110 SLL, 0111 SRL, 1000 SRA; shift amount = b[SHW-1:0], upper b bits ignored.
  - 1001 SLTU, 1010 MUL (low WIDTH of unsigned product), 1011 MULHU (high WIDTH), 1100 DIVU (quotient), 1101 REMU (remainder).
  - 1110/1111: result 0, flag_z=1, latency as single-cycle op.
- **Accept:** handshake fires when in_valid & in_ready. a, b, op are captured; the caller may change them afterwards.
- **in_ready:** = (state==IDLE), driven from registered state. No new op is accepted while busy or while a result is pending.
- **States:**
  - IDLE: on accept of a single-cycle op → DONE with result/flags registered (out_valid high the next cycle, latency 1). MUL/MULHU → MUL. DIVU/REMU with b!=0 → DIV. DIVU/REMU with b==0 → DONE directly.
  - MUL: shift-add, one bit of b per cycle, counter 0..WIDTH-1. Product register is 2*WIDTH. After WIDTH iterations → DONE. out_valid asserts WIDTH+1 cycles after accept.
  - DIV: restoring division, one quotient bit per cycle, WIDTH iterations → DONE. Same latency as MUL.
  - DONE: out_valid=1, result/flags held stable until out_ready; on out_valid & out_ready → IDLE. out_ready is ignored in other states.
- **Divide by zero:** DIVU result = all ones, REMU result = a, latency 1, flags from result.
- **ADD/SUB flags:**
  - C = carry out of the WIDTH-bit sum.
  - V = ~(a[W-1]^b_eff[W-1]) & (a[W-1]^sum[W-1]), where b_eff = b for ADD and ~b for SUB.
- **Flags for all other ops:** V=C=0; Z and N are derived from the final result for every op.
- **Outputs are registered:** no combinational path from a/b/op to result or flags.
- **Counter:** SHW bits, zeroed on entry to MUL/DIV; exit when counter == WIDTH-1 completes.

Test Plan:
1. Reset: hold rst 2 cycles, then deassert → in_ready=1, out_valid=0, result=0, flags 0. Assert rst mid-MUL (cycle 10) → IDLE next cycle, no out_valid pulse.
2. ADD/SUB flags (WIDTH=32):
   - ADD 0x7FFFFFFF+1 → result 0x80000000, V=1, N=1, C=0, Z=0, out_valid 1 cycle after accept.
   - SUB 5-5 → result 0, Z=1, C=1, V=0.
3. Shifts and compares:
   - SRA 0x80000000 by b=0x24 (amount 4) → 0xF8000000.
   - SLT 0xFFFFFFFF,1 → 1.
   - SLTU 0xFFFFFFFF,1 → 0.
4. Multiply:
   - MUL 0xFFFFFFFF*0xFFFFFFFF → 0x00000001.
   - MULHU, same operands → 0xFFFFFFFE.
   - out_valid exactly 33 cycles after accept; in_ready=0 throughout.
5. Divide:
   - DIVU 100/7 → 14; REMU → 2, 33-cycle latency.
   - DIVU 9/0 → 0xFFFFFFFF, N=1; REMU 9/0 → 9, both at latency 1.
6. Backpressure: hold out_ready=0 for 5 cycles after a MUL completes → result/flags stable, in_ready=0. Raise out_ready → in_ready=1 next cycle. Back-to-back requests with in_valid held high are each accepted exactly once. Repeat core checks with WIDTH=8.
